// File: rtl/sd_init_sequencer.sv
// SD card SPI-mode power-up sequencer: CMD0, optional CMD8, CMD55/ACMD41 poll loop, optional CMD58.
// Latency: next command issues 1 cycle after a registered cmd_done edge; cmd_start is a 1-cycle pulse.
// Backpressure: one command in flight; cmd_* fields are held stable until sd_controller reports done.
//
// Optional feature macro: SD_INIT_CMD8_EN (CMD8 voltage check + CMD58 OCR read, enables SDHC detection).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   init_start           level; rising edge starts initialisation (ignored while busy)
//   cmd/cmd_arg/cmd_crc  command frame fields for sd_controller
//   cmd_nresponse        number of response bytes sd_controller must capture
//   cmd_start            one-cycle launch pulse
//   cmd_done             sd_controller done level; rising edge = response available
//   resp_r1, resp_tail   R1 byte and bytes 2..5 of R3/R7 (MSB first)
//   busy/ready/error     sequence status; ready and error are sticky until the next init_start
//   err_code             1=CMD0 timeout 2=CMD8 bad 3=ACMD41 timeout 4=ACMD41/CMD55 bad R1 5=CMD58 bad R1
//   sdhc                 card capacity status (OCR bit 30)
module sd_init_sequencer #(
   parameter int MEMORY_SIZE_IN_BYTES = 10,
   parameter int CMD0_RETRIES         = 8,
   parameter int ACMD41_RETRIES       = 255
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    init_start,
   output logic [5:0]                              cmd,
   output logic [31:0]                             cmd_arg,
   output logic [6:0]                              cmd_crc,
   output logic [$clog2(MEMORY_SIZE_IN_BYTES)-1:0] cmd_nresponse,
   output logic                                    cmd_start,
   input  logic                                    cmd_done,
   input  logic [7:0]                              resp_r1,
   input  logic [31:0]                             resp_tail,
   output logic                                    busy,
   output logic                                    ready,
   output logic                                    error,
   output logic [2:0]                              err_code,
   output logic                                    sdhc
);

   localparam int NRW = $clog2(MEMORY_SIZE_IN_BYTES);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ISSUE_CMD0,
      S_WAIT_CMD0,
      S_ISSUE_CMD8,
      S_WAIT_CMD8,
      S_ISSUE_CMD55,
      S_WAIT_CMD55,
      S_ISSUE_ACMD41,
      S_WAIT_ACMD41,
      S_ISSUE_CMD58,
      S_WAIT_CMD58,
      S_READY,
      S_ERROR
   } state_t;

   state_t           state, state_nxt;

   logic             start_q, start_prev, start_edge;
   logic             done_q, done_prev, done_edge;
   logic [7:0]       cmd0_cnt, cmd0_cnt_nxt, cmd0_inc;
   logic [7:0]       acmd41_cnt, acmd41_cnt_nxt, acmd41_inc;
   logic             hcs, hcs_nxt;

   logic             busy_nxt, ready_nxt, error_nxt, sdhc_nxt;
   logic [2:0]       err_code_nxt, fail_code;
   logic             go_ready;
   logic [5:0]       cmd_nxt;
   logic [31:0]      cmd_arg_nxt;
   logic [6:0]       cmd_crc_nxt;
   logic [NRW-1:0]   cmd_nresponse_nxt;
   logic             cmd_start_nxt;

   assign start_edge = start_q & ~start_prev;
   assign done_edge  = done_q & ~done_prev;

`ifdef SD_INIT_CMD8_EN
   // Only the R7 echo/voltage nibble and the OCR CCS bit are inspected.
   logic unused_tail;
   assign unused_tail = ^{resp_tail[31], resp_tail[29:12]};
`else
   logic unused_tail;
   assign unused_tail = ^resp_tail;
`endif

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         start_q       <= 1'b0;
         start_prev    <= 1'b0;
         done_q        <= 1'b0;
         done_prev     <= 1'b0;
         cmd0_cnt      <= 8'd0;
         acmd41_cnt    <= 8'd0;
         hcs           <= 1'b0;
         busy          <= 1'b0;
         ready         <= 1'b0;
         error         <= 1'b0;
         err_code      <= 3'd0;
         sdhc          <= 1'b0;
         cmd           <= 6'd0;
         cmd_arg       <= 32'd0;
         cmd_crc       <= 7'h4A;
         cmd_nresponse <= '0;
         cmd_start     <= 1'b0;
      end else begin
         state         <= state_nxt;
         start_q       <= init_start;
         start_prev    <= start_q;
         done_q        <= cmd_done;
         done_prev     <= done_q;
         cmd0_cnt      <= cmd0_cnt_nxt;
         acmd41_cnt    <= acmd41_cnt_nxt;
         hcs           <= hcs_nxt;
         busy          <= busy_nxt;
         ready         <= ready_nxt;
         error         <= error_nxt;
         err_code      <= err_code_nxt;
         sdhc          <= sdhc_nxt;
         cmd           <= cmd_nxt;
         cmd_arg       <= cmd_arg_nxt;
         cmd_crc       <= cmd_crc_nxt;
         cmd_nresponse <= cmd_nresponse_nxt;
         cmd_start     <= cmd_start_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt         = state;
      cmd0_cnt_nxt      = cmd0_cnt;
      acmd41_cnt_nxt    = acmd41_cnt;
      hcs_nxt           = hcs;
      busy_nxt          = busy;
      ready_nxt         = ready;
      error_nxt         = error;
      err_code_nxt      = err_code;
      sdhc_nxt          = sdhc;
      cmd_nxt           = cmd;
      cmd_arg_nxt       = cmd_arg;
      cmd_crc_nxt       = cmd_crc;
      cmd_nresponse_nxt = cmd_nresponse;
      cmd_start_nxt     = 1'b0;
      fail_code         = 3'd0;
      go_ready          = 1'b0;
      cmd0_inc          = cmd0_cnt + 8'd1;
      // ACMD41 counter saturates so a large retry budget can never wrap to zero.
      acmd41_inc        = (acmd41_cnt == 8'hFF) ? acmd41_cnt : acmd41_cnt + 8'd1;

      case (state)
         S_IDLE, S_READY, S_ERROR: begin
            if (start_edge) begin
               ready_nxt      = 1'b0;
               error_nxt      = 1'b0;
               err_code_nxt   = 3'd0;
               sdhc_nxt       = 1'b0;
               busy_nxt       = 1'b1;
               hcs_nxt        = 1'b0;
               cmd0_cnt_nxt   = 8'd0;
               acmd41_cnt_nxt = 8'd0;
               state_nxt      = S_ISSUE_CMD0;
            end
         end

         S_ISSUE_CMD0: state_nxt = S_WAIT_CMD0;

         S_WAIT_CMD0: begin
            if (done_edge) begin
               if (resp_r1 == 8'h01) begin
`ifdef SD_INIT_CMD8_EN
                  state_nxt = S_ISSUE_CMD8;
`else
                  state_nxt = S_ISSUE_CMD55;
`endif
               end else begin
                  cmd0_cnt_nxt = cmd0_inc;
                  if (int'(cmd0_inc) >= CMD0_RETRIES) fail_code = 3'd1;
                  else                                state_nxt = S_ISSUE_CMD0;
               end
            end
         end

`ifdef SD_INIT_CMD8_EN
         S_ISSUE_CMD8: state_nxt = S_WAIT_CMD8;

         S_WAIT_CMD8: begin
            if (done_edge) begin
               if (resp_r1 == 8'h01 && resp_tail[7:0] == 8'hAA && resp_tail[11:8] == 4'h1) begin
                  hcs_nxt   = 1'b1;
                  state_nxt = S_ISSUE_CMD55;
               end else if (resp_r1[2]) begin
                  // Illegal command: v1 card, no high-capacity support.
                  hcs_nxt   = 1'b0;
                  state_nxt = S_ISSUE_CMD55;
               end else begin
                  fail_code = 3'd2;
               end
            end
         end

         S_ISSUE_CMD58: state_nxt = S_WAIT_CMD58;

         S_WAIT_CMD58: begin
            if (done_edge) begin
               if (resp_r1 == 8'h00) begin
                  sdhc_nxt = resp_tail[30];
                  go_ready = 1'b1;
               end else begin
                  fail_code = 3'd5;
               end
            end
         end
`endif

         S_ISSUE_CMD55: state_nxt = S_WAIT_CMD55;

         S_WAIT_CMD55: begin
            if (done_edge) begin
               // Idle bit may be set or clear; any other flag is a failure.
               if (resp_r1[7:1] == 7'd0) state_nxt = S_ISSUE_ACMD41;
               else                      fail_code = 3'd4;
            end
         end

         S_ISSUE_ACMD41: state_nxt = S_WAIT_ACMD41;

         S_WAIT_ACMD41: begin
            if (done_edge) begin
               if (resp_r1 == 8'h00) begin
`ifdef SD_INIT_CMD8_EN
                  if (hcs) state_nxt = S_ISSUE_CMD58;
                  else begin
                     sdhc_nxt = 1'b0;
                     go_ready = 1'b1;
                  end
`else
                  sdhc_nxt = 1'b0;
                  go_ready = 1'b1;
`endif
               end else if (resp_r1 == 8'h01) begin
                  acmd41_cnt_nxt = acmd41_inc;
                  if (int'(acmd41_inc) >= ACMD41_RETRIES) fail_code = 3'd3;
                  else                                    state_nxt = S_ISSUE_CMD55;
               end else begin
                  fail_code = 3'd4;
               end
            end
         end

         default: state_nxt = S_IDLE;
      endcase

      if (fail_code != 3'd0) begin
         state_nxt    = S_ERROR;
         error_nxt    = 1'b1;
         busy_nxt     = 1'b0;
         err_code_nxt = fail_code;
      end else if (go_ready) begin
         state_nxt = S_READY;
         ready_nxt = 1'b1;
         busy_nxt  = 1'b0;
      end

      // Command fields are registered on entry to ISSUE_x so that they and the
      // cmd_start pulse appear together, then hold through WAIT_x.
      case (state_nxt)
         S_ISSUE_CMD0: begin
            cmd_nxt           = 6'd0;
            cmd_arg_nxt       = 32'd0;
            cmd_crc_nxt       = 7'h4A;
            cmd_nresponse_nxt = NRW'(1);
            cmd_start_nxt     = 1'b1;
         end
         S_ISSUE_CMD8: begin
            cmd_nxt           = 6'd8;
            cmd_arg_nxt       = 32'h0000_01AA;
            cmd_crc_nxt       = 7'h43;
            cmd_nresponse_nxt = NRW'(5);
            cmd_start_nxt     = 1'b1;
         end
         S_ISSUE_CMD55: begin
            cmd_nxt           = 6'd55;
            cmd_arg_nxt       = 32'd0;
            cmd_crc_nxt       = 7'h32;
            cmd_nresponse_nxt = NRW'(1);
            cmd_start_nxt     = 1'b1;
         end
         S_ISSUE_ACMD41: begin
            cmd_nxt           = 6'd41;
            cmd_arg_nxt       = hcs ? 32'h4000_0000 : 32'd0;
            cmd_crc_nxt       = hcs ? 7'h3B : 7'h72;
            cmd_nresponse_nxt = NRW'(1);
            cmd_start_nxt     = 1'b1;
         end
         S_ISSUE_CMD58: begin
            cmd_nxt           = 6'd58;
            cmd_arg_nxt       = 32'd0;
            cmd_crc_nxt       = 7'h7E;
            cmd_nresponse_nxt = NRW'(5);
            cmd_start_nxt     = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/sd_init_sequencer.md
Name: sd_init_sequencer

Overview:
- Sequences the SD card SPI-mode power-up: CMD0, optional CMD8, CMD55/ACMD41 polling loop, CMD58.
- Drives the command-level port of sd_controller (cmd/arg/crc/nresponse/start/done), which in turn drives spi_controller.
- Reports ready/error and card capacity class to the host logic.

Parameters:
- MEMORY_SIZE_IN_BYTES, 10, response buffer size; sets cmd_nresponse width to $clog2(MEMORY_SIZE_IN_BYTES).
- CMD0_RETRIES, 8, number of CMD0 attempts before error.
- ACMD41_RETRIES, 255, number of CMD55+ACMD41 pairs before error; 8-bit counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- init_start  in  1  level; a rising edge starts initialisation
- cmd  out  6  command index to sd_controller
- cmd_arg  out  32  command argument
- cmd_crc  out  7  CRC7 of the command frame
- cmd_nresponse  out  $clog2(MEMORY_SIZE_IN_BYTES)  response bytes to capture
- cmd_start  out  1  one-cycle command launch pulse
- cmd_done  in  1  sd_controller done level; a rising edge marks completion
- resp_r1  in  8  first response byte (R1)
- resp_tail  in  32  bytes 2..5 of R3/R7, MSB first
- busy  out  1  sequence in progress
- ready  out  1  card initialised (sticky until the next init_start)
- error  out  1  initialisation failed (sticky until the next init_start)
- err_code  out  3  1=CMD0 timeout, 2=CMD8 bad echo/R1, 3=ACMD41 timeout, 4=ACMD41 bad R1, 5=CMD58 bad R1
- sdhc  out  1  CCS bit from OCR (bit 30)

Behaviour:
- Reset: state IDLE. busy, ready, error, sdhc and cmd_start = 0. err_code, cmd, cmd_arg and cmd_nresponse = 0. cmd_crc = 7'h4A. Retry counters = 0.
- init_start edge detection: registered. A rising edge in IDLE, READY or ERROR clears ready, error, err_code and sdhc, sets busy, and enters CMD0. Edges while busy are ignored.
- Per-command pattern (ISSUE_x, then WAIT_x):
  - ISSUE_x loads cmd, cmd_arg, cmd_crc and cmd_nresponse, and pulses cmd_start for exactly one cycle.
  - WAIT_x holds all cmd_* fields stable until a cmd_done rising edge (cmd_done registered; edge = cur & ~prev).
  - Responses are sampled in the cycle the edge is detected.
  - Command latency = 1 cycle after done to the next ISSUE.
- Command table (index, arg, crc, nresponse):
  - CMD0: 0, 0, 7'h4A, 1
  - CMD8: 8, 32'h000001AA, 7'h43, 5
  - CMD55: 55, 0, 7'h32, 1
  - ACMD41: 41, HCS ? 32'h40000000 : 0, HCS ? 7'h3B : 7'h72, 1
  - CMD58: 58, 0, 7'h7E, 5
- CMD0:
  - R1 == 8'h01: go to CMD8 (feature enabled) or CMD55.
  - Otherwise: increment counter; when the counter reaches CMD0_RETRIES, go to ERROR with code 1; else reissue CMD0.
- CMD8:
  - R1 == 8'h01 and resp_tail[7:0] == 8'hAA and resp_tail[11:8] == 4'h1: HCS = 1.
  - R1[2] set (illegal command): HCS = 0 (v1 card).
  - Otherwise: ERROR, code 2.
  - Next state is CMD55.
- CMD55: any R1 with bits [7:1] == 0 proceeds to ACMD41; otherwise ERROR, code 4.
- ACMD41:
  - R1 == 8'h00: go to CMD58 if HCS, else READY with sdhc = 0.
  - R1 == 8'h01: increment the ACMD41 counter; at ACMD41_RETRIES go to ERROR with code 3; else go to CMD55.
  - Any other value: ERROR, code 4.
- CMD58:
  - R1 == 8'h00: sdhc = resp_tail[30], go to READY.
  - Otherwise: ERROR, code 5.
- READY / ERROR:
  - busy = 0; the ready or error flag is set.
  - Only a new init_start edge leaves these states.
- Counters: reset to 0 on each init_start. ACMD41 counter saturates, with no wrap.
- Reset mid-command: everything returns to reset values immediately (asynchronous). cmd_start is never left high.
- cmd_done edge outside WAIT_x: ignored.

Optional Feature:
- Macro SD_INIT_CMD8_EN.
- Defined: CMD8 state exists and HCS is decided as above.
- Undefined: CMD8 and CMD58 are never issued, HCS = 0, sdhc stays 0, and err_code 2 and 5 are unreachable.

Test Plan:
- Ideal v2 card: R1 sequence 01, 01/tail 0x000001AA, 01, 00 (ACMD41), 00/tail 0xC0FF8000 → commands 0, 8, 55, 41, 58 issued once each; ready = 1, sdhc = 1, busy = 0; each cmd_start is exactly 1 cycle.
- ACMD41 busy 3 times (R1 = 01), then 00 → four CMD55/ACMD41 pairs; ACMD41 cmd_arg = 32'h40000000; ready = 1.
- CMD0 always returns 8'hFF → exactly CMD0_RETRIES (8) CMD0 issues, then error = 1, err_code = 1, ready = 0.
- CMD8 returns R1 = 8'h05 → HCS = 0, ACMD41 arg = 0 and crc = 7'h72, no CMD58 issued; ready = 1, sdhc = 0.
- Assert rst_n low while in WAIT_ACMD41 → all outputs at reset values on the same edge; a fresh init_start afterwards starts again from CMD0.
- Build without SD_INIT_CMD8_EN: command order is 0, 55, 41 only; ready = 1, sdhc = 0.
